q_expand_stream: RTL and testbench

- Streaming Q-format up-converter. It widens samples from Qm.n (M_I.N_I) to a wider Qm.n (M_O.N_O) by sign-extending the integer part and padding the fraction LSBs.
- It is the widening counterpart of the saturating/truncating narrower. It sits where narrow fixed-point data (ADC, decimator output) enters a wide-precision datapath (filter accumulators, mixers).
- It carries a valid/ready handshake with a registered output and a skid buffer, so it can be dropped between pipelined DSP stages.

---
 rtl/q_expand_stream.sv | 118 +++++++++++
 tb/tb_q_expand_stream.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/q_expand_stream.sv
// Streaming Qm.n widener: sign-extends the integer part, pads fraction LSBs, valid/ready with OUT + skid storage.
// Optional: define Q_EXPAND_DITHER_EN to fill the pad bits from a 32-bit Galois LFSR instead of zeros.
module q_expand_stream #(
  parameter int M_I   = 1,
  parameter int N_I   = 20,
  parameter int M_O   = 1,
  parameter int N_O   = 24,
  parameter int CNT_W = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [M_I+N_I-1:0]     sig_i,
  input  logic                   valid_i,
  output logic                   ready_o,
  output logic [M_O+N_O-1:0]     sig_o,
  output logic                   valid_o,
  input  logic                   ready_i,
  output logic [CNT_W-1:0]       cnt_o
);

  localparam int W_O = M_O + N_O;
  localparam int PAD = N_O - N_I;

  generate
    if (M_O < M_I || N_O < N_I || (N_O - N_I) > 32) begin : g_param_err
      $error("q_expand_stream: need M_O>=M_I, N_O>=N_I and N_O-N_I<=32");
    end
  endgenerate

  logic [W_O-1:0]   ext_base;
  logic [W_O-1:0]   ext;
  logic [W_O-1:0]   out_q, out_d;
  logic [W_O-1:0]   skid_q, skid_d;
  logic             out_vld_q, out_vld_d;
  logic             skid_full_q, skid_full_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             in_xfer, out_xfer;

  assign in_xfer  = valid_i && !skid_full_q;
  assign out_xfer = out_vld_q && ready_i;

  // Signed size cast sign-extends the integer part; the shift opens the zero pad.
  assign ext_base = W_O'($signed(sig_i)) << PAD;

`ifdef Q_EXPAND_DITHER_EN
  localparam logic [W_O-1:0] PAD_MASK = (W_O'(1) << PAD) - W_O'(1);

  logic [31:0] lfsr_q, lfsr_d;

  assign ext = ext_base | (W_O'(lfsr_q) & PAD_MASK);

  always_comb begin
    lfsr_d = lfsr_q;
    if (in_xfer) begin
      lfsr_d = lfsr_q[0] ? ((lfsr_q >> 1) ^ 32'h8020_0003) : (lfsr_q >> 1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lfsr_q <= 32'hACE1_2468;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end
`else
  assign ext = ext_base;
`endif

  // An input transfer never coincides with a full skid, since ready_o is !skid_full.
  always_comb begin
    out_d       = out_q;
    out_vld_d   = out_vld_q;
    skid_d      = skid_q;
    skid_full_d = skid_full_q;
    cnt_d       = cnt_q;
    if (out_xfer) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    if (!out_vld_q || ready_i) begin
      if (skid_full_q) begin
        out_d       = skid_q;
        out_vld_d   = 1'b1;
        skid_full_d = 1'b0;
      end else if (in_xfer) begin
        out_d     = ext;
        out_vld_d = 1'b1;
      end else begin
        out_vld_d = 1'b0;
      end
    end else if (in_xfer) begin
      skid_d      = ext;
      skid_full_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      out_q       <= '0;
      out_vld_q   <= 1'b0;
      skid_q      <= '0;
      skid_full_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      out_q       <= out_d;
      out_vld_q   <= out_vld_d;
      skid_q      <= skid_d;
      skid_full_q <= skid_full_d;
      cnt_q       <= cnt_d;
    end
  end

  assign sig_o   = out_q;
  assign valid_o = out_vld_q;
  assign ready_o = !skid_full_q;
  assign cnt_o   = cnt_q;

endmodule

// File: tb/tb_q_expand_stream.sv
// Bench for q_expand_stream: directed cases plus random traffic against a queue-based reference model.
module tb_q_expand_stream;

  localparam int W_I = 21;
  localparam int W_O = 25;
  localparam int PAD = 4;

  logic             clk;
  logic             rst_i;
  logic [W_I-1:0]   sig_i;
  logic             valid_i;
  logic             ready_o;
  logic [W_O-1:0]   sig_o;
  logic             valid_o;
  logic             ready_i;
  logic [31:0]      cnt_o;

  logic [W_I-1:0]   sig4_i;
  logic             valid4_i;
  logic             ready4_o;
  logic [27:0]      sig4_o;
  logic             valid4_o;
  logic             ready4_i;
  logic [31:0]      cnt4_o;

  int checks;
  int failures;

  logic [W_O-1:0] q[$];
  int unsigned    cnt_m;
  logic [31:0]    lf_m;

  q_expand_stream dut (
    .clk_i(clk), .rst_i(rst_i), .sig_i(sig_i), .valid_i(valid_i), .ready_o(ready_o),
    .sig_o(sig_o), .valid_o(valid_o), .ready_i(ready_i), .cnt_o(cnt_o)
  );

  q_expand_stream #(.M_I(1), .N_I(20), .M_O(4), .N_O(24), .CNT_W(32)) dut4 (
    .clk_i(clk), .rst_i(rst_i), .sig_i(sig4_i), .valid_i(valid4_i), .ready_o(ready4_o),
    .sig_o(sig4_o), .valid_o(valid4_o), .ready_i(ready4_i), .cnt_o(cnt4_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
  endfunction

  // Value-level widening: multiply by 2^PAD, then fill the pad field with dither if enabled.
  function automatic logic [W_O-1:0] widen(input logic [W_I-1:0] x, input logic [31:0] lf);
    longint         v;
    logic [W_O-1:0] r;
    v = longint'($signed(x)) * (longint'(1) << PAD);
    r = W_O'(v);
`ifdef Q_EXPAND_DITHER_EN
    r = r | W_O'(longint'(lf) & ((longint'(1) << PAD) - 1));
`endif
    return r;
  endfunction

  task automatic model_reset();
    q.delete();
    cnt_m = 0;
    lf_m  = 32'hACE1_2468;
  endtask

  // One clock: checks at the falling edge, model update just after the rising edge.
  task automatic step();
    logic           in_x, out_x;
    logic [W_I-1:0] s;
    @(negedge clk);
    chk("valid_o", 64'(valid_o), 64'(q.size() > 0));
    chk("ready_o", 64'(ready_o), 64'(q.size() < 2));
    chk("cnt_o", 64'(cnt_o), 64'(cnt_m));
    in_x  = !rst_i && valid_i && (q.size() < 2);
    out_x = !rst_i && ready_i && (q.size() > 0);
    s     = sig_i;
    if (out_x) chk("sig_o", 64'(sig_o), 64'(q[0]));
    @(posedge clk);
    #1;
    if (out_x) begin
      void'(q.pop_front());
      cnt_m++;
    end
    if (in_x) begin
      q.push_back(widen(s, lf_m));
      lf_m = lfsr_next(lf_m);
    end
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    rst_i = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_i    = 1'b1;
    valid_i  = 1'b0;
    ready_i  = 1'b1;
    sig_i    = '0;
    valid4_i = 1'b0;
    ready4_i = 1'b1;
    sig4_i   = '0;
    model_reset();

    @(posedge clk);
    #1;
    chk("rst_valid_o", 64'(valid_o), 64'(0));
    chk("rst_ready_o", 64'(ready_o), 64'(1));
    chk("rst_sig_o", 64'(sig_o), 64'(0));
    chk("rst_cnt_o", 64'(cnt_o), 64'(0));
    rst_i = 1'b0;

    // Zero sample first: reveals the pad source (seed LSBs or zero).
    valid_i = 1'b1;
    sig_i   = 21'h000000;
    step();
`ifdef Q_EXPAND_DITHER_EN
    chk("dither_first", 64'(sig_o), 64'(25'h0000008));
`else
    chk("pad_zero_first", 64'(sig_o), 64'(25'h0000000));
`endif
    sig_i = 21'h100000;
    step();
    chk("t1_neg1", 64'(sig_o >> 4), 64'(25'h1000000 >> 4));
    sig_i = 21'h080000;
    step();
    chk("t1_half", 64'(sig_o >> 4), 64'(25'h0800000 >> 4));
    sig_i = 21'h0FFFFF;
    step();
    chk("t1_max", 64'(sig_o >> 4), 64'(25'h0FFFFF0 >> 4));
    valid_i = 1'b0;
    step();
    step();

    // Wider integer part on the second instance.
    valid4_i = 1'b1;
    sig4_i   = 21'h100000;
    @(posedge clk);
    #1;
    chk("t2_valid", 64'(valid4_o), 64'(1));
    chk("t2_neg1", 64'(sig4_o >> 4), 64'(28'hF000000 >> 4));
    sig4_i = 21'h000001;
    @(posedge clk);
    #1;
    chk("t2_lsb", 64'(sig4_o >> 4), 64'(28'h0000010 >> 4));
`ifndef Q_EXPAND_DITHER_EN
    chk("t2_pad", 64'(sig4_o & 28'hF), 64'(0));
`endif
    valid4_i = 1'b0;
    @(posedge clk);
    #1;
    chk("t2_cnt", 64'(cnt4_o), 64'(2));

    // Backpressure: A to OUT, B to SKID, C held until space frees up.
    do_reset();
    ready_i = 1'b0;
    valid_i = 1'b1;
    sig_i   = 21'h012345;
    step();
    sig_i = 21'h1ABCDE;
    step();
    chk("t3_ready_low", 64'(ready_o), 64'(0));
    sig_i = 21'h0F0F0F;
    step();
    chk("t3_hold_A", 64'(sig_o >> 4), 64'(25'h0123450 >> 4));
    step();
    ready_i = 1'b1;
    step();
    chk("t3_B_out", 64'(sig_o >> 4), 64'(25'h1ABCDE0 >> 4));
    step();
    valid_i = 1'b0;
    chk("t3_C_out", 64'(sig_o >> 4), 64'(25'h00F0F0F0 >> 4));
    step();
    chk("t3_cnt", 64'(cnt_o), 64'(3));

    // Full-rate streaming.
    do_reset();
    ready_i = 1'b1;
    valid_i = 1'b1;
    for (int unsigned i = 0; i < 100; i++) begin
      sig_i = W_I'($urandom);
      step();
    end
    valid_i = 1'b0;
    step();
    @(negedge clk);
    chk("t4_cnt", 64'(cnt_o), 64'(100));
    @(posedge clk);
    #1;

    // Asynchronous reset with both entries occupied.
    ready_i = 1'b0;
    valid_i = 1'b1;
    sig_i   = 21'h055555;
    step();
    sig_i = 21'h0AAAAA;
    step();
    #2;
    rst_i = 1'b1;
    #1;
    chk("t5_valid_o", 64'(valid_o), 64'(0));
    chk("t5_cnt_o", 64'(cnt_o), 64'(0));
    chk("t5_ready_o", 64'(ready_o), 64'(1));
    model_reset();
    step();
    rst_i   = 1'b0;
    ready_i = 1'b1;
    sig_i   = 21'h000001;
    step();
    chk("t5_latency_valid", 64'(valid_o), 64'(1));
    chk("t5_latency_sig", 64'(sig_o >> 4), 64'(25'h0000010 >> 4));
    valid_i = 1'b0;
    step();

    // Random valid/ready traffic.
    do_reset();
    for (int unsigned i = 0; i < 400; i++) begin
      valid_i = ($urandom_range(0, 3) != 0);
      ready_i = ($urandom_range(0, 2) != 0);
      sig_i   = W_I'($urandom);
      step();
    end
    valid_i = 1'b0;
    ready_i = 1'b1;
    step();
    step();
    step();
    chk("rand_drained", 64'(valid_o), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
